// File: rtl/emitter_sequencer_if.sv
// Signals between the emitter sequencer, the stitcher, the sample-buffer read port
// and the left/right Avalon-ST codec sinks.
interface emitter_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [1:0]        window_start;
    logic              go_in;
    logic              busy;
    logic              done;
    logic              go_dropped;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] left_out_data;
    logic              left_out_valid;
    logic              left_out_ready;
    logic [DATA_W-1:0] right_out_data;
    logic              right_out_valid;
    logic              right_out_ready;

    modport master (
        input  window_start, go_in, rd_data, left_out_ready, right_out_ready,
        output busy, done, go_dropped, rd_addr,
        output left_out_data, left_out_valid, right_out_data, right_out_valid
    );

    modport slave (
        output window_start, go_in, rd_data, left_out_ready, right_out_ready,
        input  busy, done, go_dropped, rd_addr,
        input  left_out_data, left_out_valid, right_out_data, right_out_valid
    );
endinterface

// File: rtl/emitter_sequencer.sv
// Reads one window of stitched samples per go and hands each sample to both codec
// channels, advancing only once left and right have each accepted it.
module emitter_sequencer #(
    parameter int DATA_W   = 16,
    parameter int SLOT_LEN = 256,
    parameter int EMIT_LEN = 256,
    parameter int ADDR_W   = 10
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    emitter_sequencer_if.master io_seq
);
    // state   | meaning
    // IDLE    | waiting for an accepted go_in
    // ISSUE   | rd_addr stable, RAM samples it at the end of this cycle
    // LOAD    | rd_data valid, captured into both channel registers
    // PRESENT | sample offered on both channels until each has accepted
    // DONE    | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LOAD, S_PRESENT, S_DONE} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(EMIT_LEN - 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr_nxt;
    logic [ADDR_W:0]     r_idx, w_idx_nxt;
    logic [DATA_W-1:0]   r_left_data, w_left_data_nxt;
    logic [DATA_W-1:0]   r_right_data, w_right_data_nxt;
    logic                r_left_valid, w_left_valid_nxt;
    logic                r_right_valid, w_right_valid_nxt;
    logic                r_go_dropped, w_go_dropped_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                w_left_taken, w_right_taken, w_both_taken;
    logic [ADDR_W-1:0]   w_base;

    // A channel counts as taken if it was already accepted or is accepted at this edge.
    assign w_left_taken  = !r_left_valid  || io_seq.left_out_ready;
    assign w_right_taken = !r_right_valid || io_seq.right_out_ready;
    assign w_both_taken  = w_left_taken && w_right_taken;
    assign w_base        = ADDR_W'(io_seq.window_start) * ADDR_W'(SLOT_LEN);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (io_seq.go_in) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_LOAD;
            S_LOAD:    w_state_nxt = S_PRESENT;
            S_PRESENT: if (w_both_taken) w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_ISSUE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_addr_nxt     = r_rd_addr;
        w_idx_nxt         = r_idx;
        w_left_data_nxt   = r_left_data;
        w_right_data_nxt  = r_right_data;
        w_left_valid_nxt  = r_left_valid;
        w_right_valid_nxt = r_right_valid;
        w_go_dropped_nxt  = r_go_dropped;
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_done_nxt        = (w_state_nxt == S_DONE);
        if (io_seq.go_in) w_go_dropped_nxt = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (io_seq.go_in) begin
                    w_rd_addr_nxt = w_base;
                    w_idx_nxt     = '0;
                end
            end
            S_LOAD: begin
                w_left_data_nxt   = io_seq.rd_data;
                w_right_data_nxt  = io_seq.rd_data;
                w_left_valid_nxt  = 1'b1;
                w_right_valid_nxt = 1'b1;
            end
            S_PRESENT: begin
                if (r_left_valid && io_seq.left_out_ready)   w_left_valid_nxt  = 1'b0;
                if (r_right_valid && io_seq.right_out_ready) w_right_valid_nxt = 1'b0;
                if (w_both_taken && (r_idx != LAST_IDX)) begin
                    w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
                    w_idx_nxt     = r_idx + (ADDR_W+1)'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_addr     <= '0;
            r_idx         <= '0;
            r_left_data   <= '0;
            r_right_data  <= '0;
            r_left_valid  <= 1'b0;
            r_right_valid <= 1'b0;
            r_go_dropped  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_rd_addr     <= w_rd_addr_nxt;
            r_idx         <= w_idx_nxt;
            r_left_data   <= w_left_data_nxt;
            r_right_data  <= w_right_data_nxt;
            r_left_valid  <= w_left_valid_nxt;
            r_right_valid <= w_right_valid_nxt;
            r_go_dropped  <= w_go_dropped_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign io_seq.rd_addr         = r_rd_addr;
    assign io_seq.left_out_data   = r_left_data;
    assign io_seq.left_out_valid  = r_left_valid;
    assign io_seq.right_out_data  = r_right_data;
    assign io_seq.right_out_valid = r_right_valid;
    assign io_seq.go_dropped      = r_go_dropped;
    assign io_seq.busy            = r_busy;
    assign io_seq.done            = r_done;
endmodule

// File: tb/tb_emitter_sequencer.sv
// Scoreboard bench: each accepted go queues the window's expected samples, and a
// negedge monitor pops them as either codec channel accepts.
module tb_emitter_sequencer;
    localparam int DATA_W   = 16;
    localparam int SLOT_LEN = 256;
    localparam int EMIT_LEN = 300;
    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 4 * SLOT_LEN;
    localparam int BUDGET   = EMIT_LEN * 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    emitter_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_if();

    emitter_sequencer #(
        .DATA_W(DATA_W), .SLOT_LEN(SLOT_LEN), .EMIT_LEN(EMIT_LEN), .ADDR_W(ADDR_W)
    ) u_dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .io_seq(u_if.master)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) u_if.rd_data <= mem[u_if.rd_addr];

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_l[$];
    logic [DATA_W-1:0] exp_r[$];
    int   rdy_mode = 0;         // 0: both ready, 1: random stalls, 2: man_l/man_r
    logic man_l = 1'b1;
    logic man_r = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the window is simply EMIT_LEN consecutive buffer words, wrapping.
    task automatic start_window(input logic [1:0] ws);
        for (int i = 0; i < EMIT_LEN; i++) begin
            exp_l.push_back(mem[(int'(ws) * SLOT_LEN + i) % DEPTH]);
            exp_r.push_back(mem[(int'(ws) * SLOT_LEN + i) % DEPTH]);
        end
        u_if.window_start = ws;
        u_if.go_in = 1'b1;
        tick();
        u_if.go_in = 1'b0;
        u_if.window_start = ~ws;
        chk("busy_on_accept", u_if.busy, 1);
        chk("go_dropped_cleared", u_if.go_dropped, 0);
        chk("valid_after_k", u_if.left_out_valid, 0);
        tick();
        chk("valid_after_k1", u_if.right_out_valid, 0);
        tick();
        chk("left_valid_after_k2", u_if.left_out_valid, 1);
        chk("right_valid_after_k2", u_if.right_out_valid, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (u_if.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", u_if.done, 1);
    endtask

    initial begin : ready_drv
        u_if.left_out_ready = 1'b0;
        u_if.right_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: begin
                    u_if.left_out_ready = 1'b1;
                    u_if.right_out_ready = 1'b1;
                end
                1: begin
                    u_if.left_out_ready = ($urandom_range(0, 3) != 0);
                    u_if.right_out_ready = ($urandom_range(0, 3) != 0);
                end
                default: begin
                    u_if.left_out_ready = man_l;
                    u_if.right_out_ready = man_r;
                end
            endcase
        end
    end

    initial begin : monitor
        int cyc;
        int l_last;
        logic exp_done, prev_done, l_acc, r_acc;
        logic pl_v, pl_a, pr_v, pr_a;
        logic [DATA_W-1:0] pl_d, pr_d;
        cyc = 0; l_last = -1; exp_done = 0; prev_done = 0;
        pl_v = 0; pl_a = 0; pr_v = 0; pr_a = 0; pl_d = '0; pr_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_l.delete();
                exp_r.delete();
                exp_done = 0; prev_done = 0; pl_v = 0; pr_v = 0; l_last = -1;
                continue;
            end
            chk("done_pulse", u_if.done, exp_done);
            if (prev_done) chk("busy_low_after_done", u_if.busy, 0);
            prev_done = u_if.done;
            exp_done = 0;
            if (pl_v && !pl_a) begin
                chk("left_valid_held", u_if.left_out_valid, 1);
                chk("left_data_held", u_if.left_out_data, pl_d);
            end
            if (pr_v && !pr_a) begin
                chk("right_valid_held", u_if.right_out_valid, 1);
                chk("right_data_held", u_if.right_out_data, pr_d);
            end
            l_acc = u_if.left_out_valid && u_if.left_out_ready;
            r_acc = u_if.right_out_valid && u_if.right_out_ready;
            if (l_acc) begin
                if (exp_l.size() == 0) chk("left_unexpected_sample", 1, 0);
                else chk("left_data", u_if.left_out_data, exp_l.pop_front());
                if (rdy_mode == 0 && l_last >= 0) chk("left_spacing", cyc - l_last, 3);
                l_last = cyc;
            end
            if (r_acc) begin
                if (exp_r.size() == 0) chk("right_unexpected_sample", 1, 0);
                else chk("right_data", u_if.right_out_data, exp_r.pop_front());
            end
            if ((l_acc || r_acc) && exp_l.size() == 0 && exp_r.size() == 0) begin
                exp_done = 1;
                l_last = -1;
            end
            pl_v = u_if.left_out_valid;  pl_a = l_acc; pl_d = u_if.left_out_data;
            pr_v = u_if.right_out_valid; pr_a = r_acc; pr_d = u_if.right_out_data;
        end
    end

    initial begin : stim
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        u_if.go_in = 1'b0;
        u_if.window_start = 2'd0;
        repeat (3) tick();
        chk("rst_busy", u_if.busy, 0);
        chk("rst_done", u_if.done, 0);
        chk("rst_go_dropped", u_if.go_dropped, 0);
        chk("rst_left_valid", u_if.left_out_valid, 0);
        chk("rst_right_valid", u_if.right_out_valid, 0);
        chk("rst_rd_addr", u_if.rd_addr, 0);
        chk("rst_left_data", u_if.left_out_data, 0);
        rst_n = 1'b1;
        tick();

        rdy_mode = 0;
        start_window(2'd1);
        wait_done(BUDGET);
        tick();

        start_window(2'd3);
        wait_done(BUDGET);
        chk("wrap_last_addr", u_if.rd_addr, (3 * SLOT_LEN + EMIT_LEN - 1) % DEPTH);
        chk("wrap_last_data", u_if.left_out_data, mem[(3 * SLOT_LEN + EMIT_LEN - 1) % DEPTH]);
        tick();

        rdy_mode = 2; man_l = 1'b1; man_r = 1'b0;
        start_window(2'd0);
        repeat (5) tick();
        chk("skew_left_valid", u_if.left_out_valid, 0);
        chk("skew_right_valid", u_if.right_out_valid, 1);
        chk("skew_left_count", EMIT_LEN - exp_l.size(), 1);
        chk("skew_right_count", EMIT_LEN - exp_r.size(), 0);
        chk("skew_addr_hold", u_if.rd_addr, 0);
        man_r = 1'b1;
        repeat (2) tick();
        rdy_mode = 1;
        wait_done(BUDGET);
        tick();

        start_window(2'd2);
        repeat (20) tick();
        u_if.window_start = 2'd0;
        u_if.go_in = 1'b1;
        tick();
        u_if.go_in = 1'b0;
        chk("drop_mid_flag", u_if.go_dropped, 1);
        chk("drop_mid_busy", u_if.busy, 1);
        wait_done(BUDGET);
        u_if.window_start = 2'd1;
        u_if.go_in = 1'b1;
        tick();
        u_if.go_in = 1'b0;
        chk("drop_done_busy", u_if.busy, 0);
        chk("drop_done_flag", u_if.go_dropped, 1);
        tick();
        chk("drop_flag_sticky", u_if.go_dropped, 1);
        start_window(2'd1);
        wait_done(BUDGET);
        tick();

        start_window(2'd0);
        n = 0;
        while (!((EMIT_LEN - exp_l.size()) >= 2 && u_if.left_out_valid) && n < 400) begin
            tick();
            n++;
        end
        chk("reset_reach_sample2", (n < 400), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_left_valid", u_if.left_out_valid, 0);
        chk("abort_right_valid", u_if.right_out_valid, 0);
        chk("abort_busy", u_if.busy, 0);
        chk("abort_done", u_if.done, 0);
        chk("abort_rd_addr", u_if.rd_addr, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rdy_mode = 0;
        start_window(2'd0);
        wait_done(BUDGET);
        tick();

        rdy_mode = 1;
        for (int w = 0; w < 3; w++) begin
            start_window(2'($urandom_range(0, 3)));
            wait_done(BUDGET);
            tick();
        end

        repeat (3) tick();
        chk("left_queue_drained", exp_l.size(), 0);
        chk("right_queue_drained", exp_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/emitter_sequencer.md
Name: emitter_sequencer

Overview:
- Sequences the codec output path. On each go pulse from the stitcher, it reads one window of stitched samples from the output sample buffer, a synchronous RAM with 1-cycle read latency.
- Each sample is presented to both the left and the right Avalon-ST to_dac sinks of the Wolfson codec.
- It advances only when both channels have accepted the current sample.
- It reports busy/done back to the stitcher and flags go pulses that arrive while it cannot accept them.

Parameters:
- DATA_W, 16, sample width (codec channel width).
- SLOT_LEN, 256, samples per window slot; buffer depth = 4*SLOT_LEN.
- EMIT_LEN, 256, samples emitted per go; legal range 1..4*SLOT_LEN.
- ADDR_W, 10, buffer address width; must equal clog2(4*SLOT_LEN).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- window_start  in  2  slot index of the first sample; sampled only when go is accepted.
- go_in  in  1  start request from stitcher, one cycle wide.
- busy  out  1  high from go accept until return to IDLE.
- done  out  1  one-cycle pulse after the last sample of a window is accepted by both channels.
- go_dropped  out  1  sticky; set by a go_in that is not accepted; cleared on the next accepted go.
- rd_addr  out  ADDR_W  registered read address to the sample buffer.
- rd_data  in  DATA_W  buffer data; valid the cycle after the RAM samples rd_addr.
- left_out_data  out  DATA_W  sample to avalon_left_channel_sink.
- left_out_valid  out  1  Avalon-ST valid, left.
- left_out_ready  in  1  Avalon-ST ready, left.
- right_out_data  out  DATA_W  sample to avalon_right_channel_sink.
- right_out_valid  out  1  Avalon-ST valid, right.
- right_out_ready  in  1  Avalon-ST ready, right.

Behaviour:
- Reset (async assert, synchronous deassert by construction):
  - All outputs 0; state IDLE; sample index 0.
  - Reset asserted mid-window aborts the window immediately: valids drop and no done is issued.
- States and transitions:
  - IDLE: when go_in=1, latch base = window_start*SLOT_LEN, set rd_addr <= base, idx <= 0, busy <= 1, go_dropped <= 0, go to ISSUE.
  - ISSUE: RAM samples rd_addr at this edge; go to LOAD.
  - LOAD: left_out_data and right_out_data <= rd_data; both valids <= 1; go to PRESENT.
  - PRESENT, per channel: if valid and ready at an edge, that channel's valid <= 0. Data registers stay stable while either valid is high.
  - PRESENT, completion: both accepted means each channel either already has valid=0 or is accepted at this edge.
    - If both accepted and idx = EMIT_LEN-1: go to DONE.
    - If both accepted otherwise: rd_addr <= (rd_addr+1) mod 2^ADDR_W, idx <= idx+1, go to ISSUE.
  - DONE: done=1 for exactly this cycle, busy <= 0; go to IDLE.
- Address wrap: the address wraps modulo 4*SLOT_LEN. Example: window_start=3 with EMIT_LEN > SLOT_LEN continues at address 0.
- Latency:
  - go_in accepted at edge k: busy high after k; valids high after edge k+2.
  - Minimum 3 cycles per sample when both readies are held high.
  - Last acceptance at edge m: done high in cycle m..m+1; busy low after m+1.
- Each channel deasserts valid independently, so a channel is never handed the same sample twice.
- Handshake with no ready: if ready never arrives, the block waits indefinitely. There is no timeout.
- go_in handling:
  - go_in in any state other than IDLE (including the DONE cycle) is ignored and sets go_dropped.
  - window_start changes while busy have no effect.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic window: buffer mem[i]=i; EMIT_LEN=4, window_start=1, readies held 1, pulse go → both channels emit 256,257,258,259 at 3-cycle spacing; done pulses once; busy low afterwards.
- Skewed readies: left_out_ready=1, right_out_ready held 0 for 5 cycles then 1 → left valid drops after 1 accept; no next sample until right accepts 256; left receives 256 exactly once.
- Wrap: EMIT_LEN=300, window_start=3 → addresses 768..1023 then 0..43; last sample data 43; done after the 300th dual acceptance.
- Dropped go: go_in pulsed mid-window and again in the DONE cycle → both ignored; go_dropped=1 until the next accepted go, then 0; window_start sampled only at accept.
- Reset mid-window: assert reset_n=0 during PRESENT after sample 2 → all valids, busy and done go 0 asynchronously; after release, a go with window_start=0 starts cleanly from address 0.
- Back-pressure stability: random ready stalls over 64 samples → data held stable while valid; output sequence equals buffer contents in order on both channels.
